serial_adder_shift_ctrl: RTL and testbench

Bit-serial adder datapath and controller that feeds the one-bit full-adder cell one operand bit pair per clock and collects its sum and carry. It sits directly upstream of the full-adder cell, with the cell instantiated inside. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It returns a WIDTH-bit sum and carry-out over a second valid/ready handshake after WIDTH shift cycles.

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/full_adder_cell.sv | 15 +
 rtl/serial_adder_shift_ctrl.sv | 116 +++++++++++
 tb/tb_serial_adder_shift_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
// No logic; imported by the controller.
// Encodings are fixed so the spare code 2'b11 is well defined as "unused".
package serial_adder_pkg;

  localparam int WIDTH_DEFAULT = 8;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_HOLD  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    HOLD  = ST_HOLD
  } state_e;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder, purely combinational.
// Latency: zero cycles. Backpressure: none (no state, no handshake).
// Ports: a, b, c -> s (sum bit), car (carry out).
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic car
);

  assign s   = a ^ b ^ c;
  assign car = (a & b) | (b & c) | (c & a);

endmodule

// File: rtl/serial_adder_shift_ctrl.sv
// Bit-serial adder: captures A/B/cin, feeds one bit pair per clock to a full-adder cell.
// Latency: out_valid rises WIDTH edges after the accepting edge; one op per WIDTH+2 cycles.
// Backpressure: result held stable in HOLD while out_ready is low; in_ready only in IDLE.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with a_in, b_in, cin;
//        out_valid/out_ready with sum, cout.
module serial_adder_shift_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic fa_s;
  logic fa_car;

  full_adder_cell u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .c   (carry_q),
    .s   (fa_s),
    .car (fa_car)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Sum bits enter at the MSB so bit 0 lands at position 0 after WIDTH shifts.
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_car;
        if (cnt_q == CNT_LAST) begin
          // Counter parks at its last value rather than wrapping.
          cout_d  = fa_car;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        // Spare encoding recovers to IDLE.
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_shift_ctrl.sv
// Scoreboard bench for serial_adder_shift_ctrl at WIDTH=8 and WIDTH=2.
module tb_serial_adder_shift_ctrl;

  localparam int W  = 8;
  localparam int W2 = 2;
  typedef logic [W:0]  res_t;
  typedef logic [W2:0] res2_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, cin, cout;
  logic [W-1:0] a_in, b_in, sum;

  logic          in_valid2, in_ready2, out_valid2, out_ready2, cin2, cout2;
  logic [W2-1:0] a2, b2, sum2;

  serial_adder_shift_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  serial_adder_shift_ctrl #(.WIDTH(W2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .a_in(a2), .b_in(b2), .cin(cin2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  res_t  exp_q[$];
  int    acc_q[$];
  res2_t exp2_q[$];
  logic  rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference model: plain unsigned addition, carry out is the extra MSB.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return res_t'(a) + res_t'(b) + res_t'(c);
  endfunction

  // Monitor for the 8-bit instance: latency on each rising out_valid, result on each output handshake.
  logic prev_ov = 1'b0;
  res_t mon_e;
  int   mon_a;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) fail_now("unexpected_out_valid");
        else begin
          mon_a = acc_q.pop_front();
          check("latency", 64'(cyc - mon_a), 64'(W));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_result");
        else begin
          mon_e = exp_q.pop_front();
          check("result", 64'({cout, sum}), 64'(mon_e));
        end
      end
      prev_ov = out_valid;
    end
  end

  res2_t mon2_e;
  always @(negedge clk) begin
    if (rst_n && out_valid2 && out_ready2) begin
      if (exp2_q.size() == 0) fail_now("w2_unexpected_result");
      else begin
        mon2_e = exp2_q.pop_front();
        check("w2_result", 64'({cout2, sum2}), 64'(mon2_e));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int n;
    n = 0;
    a_in = a; b_in = b; cin = c; in_valid = 1'b1;
    while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      fail_now("issue_timeout");
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(a, b, c));
    acc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp2_q.size() != 0) && n < 1000) begin @(posedge clk); #1; n++; end
    check("drain_empty", 64'(exp_q.size() + exp2_q.size()), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int n;
    int acc;
    int prev_acc;
    logic [4:0] v;
    res_t bp_exp;

    rst_n = 1'b0;
    in_valid = 1'b0; a_in = '0; b_in = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; out_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors from the test plan.
    issue(8'h00, 8'h00, 1'b0);
    issue(8'hFF, 8'h01, 1'b0);
    issue(8'hA5, 8'h5A, 1'b1);
    issue(8'hA5, 8'h5A, 1'b0);
    drain();

    // Backpressure, with operand pulses during SHIFT and HOLD that must be ignored.
    out_ready = 1'b0;
    bp_exp = model(8'h9E, 8'h77, 1'b0);
    issue(8'h9E, 8'h77, 1'b0);
    a_in = 8'hFF; b_in = 8'hFF; cin = 1'b1; in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (!out_valid) fail_now("bp_wait_out_valid");
    repeat (5) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_sum_stable", 64'(sum), 64'(bp_exp[W-1:0]));
      check("bp_cout_stable", 64'(cout), 64'(bp_exp[W]));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset after three SHIFT edges.
    issue(8'h33, 8'h44, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_sum", 64'(sum), 64'd0);
    check("abort_cout", 64'(cout), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(8'h0F, 8'h01, 1'b0);
    drain();

    // Random operands with random downstream stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
    end
    rand_rdy = 1'b0;
    #1;
    out_ready = 1'b1;
    drain();

    // Exhaustive WIDTH=2, back-to-back, checking accept spacing.
    prev_acc = 0;
    in_valid2 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      v = i[4:0];
      a2 = v[4:3]; b2 = v[2:1]; cin2 = v[0];
      n = 0;
      while (!in_ready2 && n < 50) begin @(posedge clk); #1; n++; end
      if (!in_ready2) begin
        fail_now("w2_issue_timeout");
        break;
      end
      acc = cyc + 1;
      exp2_q.push_back(res2_t'(v[4:3]) + res2_t'(v[2:1]) + res2_t'(v[0]));
      if (i > 0) check("w2_spacing", 64'(acc - prev_acc), 64'(W2 + 2));
      prev_acc = acc;
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
